// File: rtl/sa_inst_pkg.sv
// Shared definitions for the systolic-array instruction path: opcodes, field positions,
// per-opcode cycle table and sequencer FSM encoding (S_ERR exists only with SEQ_TIMEOUT_EN).
package sa_inst_pkg;

   localparam int OPCODE_W   = 4;
   localparam int CNT_W      = 8;

   localparam int OP_FROM    = 0;
   localparam int OP_TO      = 3;
   localparam int ADDRA_FROM = 4;
   localparam int ADDRA_TO   = 17;
   localparam int ADDRB_FROM = 18;
   localparam int ADDRB_TO   = 31;

   localparam logic [OPCODE_W-1:0] IDLE_INST              = 4'h0;
   localparam logic [OPCODE_W-1:0] AXI_TO_UB_INST         = 4'h1;
   localparam logic [OPCODE_W-1:0] AXI_TO_WB_INST         = 4'h2;
   localparam logic [OPCODE_W-1:0] UB_TO_DATA_FIFO_INST   = 4'h3;
   localparam logic [OPCODE_W-1:0] UB_TO_WEIGHT_FIFO_INST = 4'h4;
   localparam logic [OPCODE_W-1:0] MAT_MUL_INST           = 4'h5;
   localparam logic [OPCODE_W-1:0] MAT_MUL_ACC_INST       = 4'h6;
   localparam logic [OPCODE_W-1:0] ACC_TO_UB_INST         = 4'h7;
   localparam logic [OPCODE_W-1:0] UB_TO_AXI_INST         = 4'h8;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT_LO = 3'd2,
      S_WAIT_HI = 3'd3,
      S_COUNT   = 3'd4
`ifdef SEQ_TIMEOUT_EN
      , S_ERR   = 3'd5
`endif
   } state_t;

   function automatic logic is_axi_op(input logic [OPCODE_W-1:0] op);
      return (op == AXI_TO_UB_INST) || (op == AXI_TO_WB_INST) || (op == UB_TO_AXI_INST);
   endfunction

   // Cycles an op is held on the bus; anything not listed (including unknown codes) takes one.
   function automatic logic [CNT_W-1:0] op_cycles(input logic [OPCODE_W-1:0] op);
      case (op)
         UB_TO_DATA_FIFO_INST:   return 8'd4;
         UB_TO_WEIGHT_FIFO_INST: return 8'd4;
         MAT_MUL_INST:           return 8'd8;
         MAT_MUL_ACC_INST:       return 8'd8;
         ACC_TO_UB_INST:         return 8'd4;
         default:                return 8'd1;
      endcase
   endfunction

endpackage

// File: rtl/sa_inst_fifo.sv
// First-word-fall-through synchronous FIFO holding host instructions.
// A push into a full FIFO is dropped even if a pop happens in the same cycle.
module sa_inst_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_wr_en;
   logic             w_rd_en;

   assign o_full  = (r_level == (AW+1)'(DEPTH));
   assign o_empty = (r_level == '0);
   assign w_wr_en = i_push && !o_full;
   assign w_rd_en = i_pop && !o_empty;
   assign o_data  = r_mem[r_rd_ptr];
   assign o_level = r_level;

   // NOTE: storage is not reset; pointers and level alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
   end

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr_en, w_rd_en})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/sa_inst_sequencer.sv
// Host-fed instruction sequencer: buffers words and holds each on the array bus until it completes.
// Defining SEQ_TIMEOUT_EN adds a flag-handshake watchdog with a sticky error state.
module sa_inst_sequencer
   import sa_inst_pkg::*;
#(
   parameter int INST_BITS   = 32,
   parameter int OPCODE_BITS = 4,
   parameter int FIFO_DEPTH  = 16,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [INST_BITS-1:0]        s_inst,
   input  logic                        s_valid,
   output logic                        s_ready,
   output logic [INST_BITS-1:0]        instruction,
   input  logic                        flag,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [15:0]                 issued_cnt,
   output logic                        timeout_err
);
   localparam logic [INST_BITS-1:0] IDLE_WORD = INST_BITS'(IDLE_INST);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [INST_BITS-1:0]   r_inst;
   logic [INST_BITS-1:0]   w_inst_nxt;
   logic [INST_BITS-1:0]   w_head;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic [CNT_W-1:0]       w_cyc;
   logic [OPCODE_BITS-1:0] w_opcode;
   logic [15:0]            r_issued;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_pop;
   logic                   w_done;

   sa_inst_fifo #(
      .WIDTH (INST_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (s_valid),
      .i_data  (s_inst),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (fifo_level)
   );

   assign w_opcode    = r_inst[OP_TO:OP_FROM];
   assign w_cyc       = op_cycles(w_opcode);
   assign s_ready     = !w_full;
   assign instruction = r_inst;
   assign issued_cnt  = r_issued;
   assign busy        = (r_state != S_IDLE) || (fifo_level != '0);

`ifdef SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] r_wdog;
   logic [WD_W-1:0] w_wdog_nxt;
   logic            r_terr;
   logic            w_terr_nxt;
   assign timeout_err = r_terr;
`else
   assign timeout_err = (TIMEOUT_CYC < 0);
`endif

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_inst_nxt  = r_inst;
      w_cnt_nxt   = r_cnt;
      w_pop       = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_inst_nxt  = w_head;
               w_state_nxt = S_ISSUE;
            end
         end
         // ISSUE is the first held cycle, so COUNT covers the remaining CYC-1 cycles.
         S_ISSUE: begin
            if (is_axi_op(w_opcode)) begin
               w_state_nxt = S_WAIT_LO;
            end else if (w_cyc <= CNT_W'(1)) begin
               w_done = 1'b1;
            end else begin
               w_cnt_nxt   = w_cyc - CNT_W'(2);
               w_state_nxt = S_COUNT;
            end
         end
         S_WAIT_LO: if (!flag) w_state_nxt = S_WAIT_HI;
         S_WAIT_HI: if (flag) w_done = 1'b1;
         S_COUNT: begin
            if (r_cnt == '0) w_done = 1'b1;
            else             w_cnt_nxt = r_cnt - 1'b1;
         end
`ifdef SEQ_TIMEOUT_EN
         S_ERR: w_state_nxt = S_ERR;
`endif
         default: begin
            w_state_nxt = S_IDLE;
            w_inst_nxt  = IDLE_WORD;
         end
      endcase

      if (w_done) begin
         if (!w_empty) begin
            w_pop       = 1'b1;
            w_inst_nxt  = w_head;
            w_state_nxt = S_ISSUE;
         end else begin
            w_inst_nxt  = IDLE_WORD;
            w_state_nxt = S_IDLE;
         end
      end

`ifdef SEQ_TIMEOUT_EN
      w_wdog_nxt = '0;
      w_terr_nxt = r_terr;
      if ((r_state == S_WAIT_LO || r_state == S_WAIT_HI) && !w_done) begin
         if (r_wdog == WD_W'(TIMEOUT_CYC - 1)) begin
            w_terr_nxt  = 1'b1;
            w_inst_nxt  = IDLE_WORD;
            w_state_nxt = S_ERR;
         end else begin
            w_wdog_nxt = r_wdog + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_inst   <= IDLE_WORD;
         r_cnt    <= '0;
         r_issued <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_inst   <= w_inst_nxt;
         r_cnt    <= w_cnt_nxt;
         r_issued <= r_issued + 16'(w_done);
      end
   end

`ifdef SEQ_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wdog <= '0;
         r_terr <= 1'b0;
      end else begin
         r_wdog <= w_wdog_nxt;
         r_terr <= w_terr_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_sa_inst_sequencer.sv
// Scoreboard bench for sa_inst_sequencer: stimulus queues expected issues with their hold times,
// an independent monitor checks every change of the instruction bus against that queue.
module tb_sa_inst_sequencer;
   import sa_inst_pkg::*;

   typedef struct packed {
      logic [31:0] word;
      logic [15:0] hold;   // expected cycles on the bus; 0 = not timed
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] s_inst = '0;
   logic        s_valid = 1'b0;
   logic        flag = 1'b1;
   logic        s_ready;
   logic [31:0] instruction;
   logic        busy;
   logic [4:0]  fifo_level;
   logic [15:0] issued_cnt;
   logic        timeout_err;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          exp_issued = 0;

   logic [31:0] mon_prev = '0;
   int          mon_start = 0;
   int          mon_hold = 0;
   exp_t        mon_e;

   sa_inst_sequencer #(
      .INST_BITS   (32),
      .OPCODE_BITS (4),
      .FIFO_DEPTH  (16),
      .TIMEOUT_CYC (4096)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .s_inst      (s_inst),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .instruction (instruction),
      .flag        (flag),
      .busy        (busy),
      .fifo_level  (fifo_level),
      .issued_cnt  (issued_cnt),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk(input logic [3:0] op, input logic [13:0] a, input logic [13:0] b);
      return {b, a, op};
   endfunction

   task automatic push(input logic [31:0] w, input int hold, input logic accept, input int lvl);
      @(negedge clk);
      s_inst  = w;
      s_valid = 1'b1;
      check("s_ready", 64'(s_ready), 64'(accept));
      if (accept) exp_q.push_back('{word: w, hold: 16'(hold)});
      @(posedge clk);
      #1 s_valid = 1'b0;
      if (lvl >= 0) check("fifo_level", 64'(fifo_level), 64'(lvl));
   endtask

   task automatic wait_word(input logic [31:0] w);
      int n = 0;
      @(negedge clk);
      while (instruction !== w && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("issue_seen", 64'(instruction), 64'(w));
   endtask

   // Flag drops d cycles after issue and rises r cycles later; done is seen one edge after the rise.
   task automatic axi_handshake(input logic [31:0] w, input int d, input int r);
      wait_word(w);
      repeat (d) @(posedge clk);
      #1 flag = 1'b0;
      repeat (r) @(posedge clk);
      #1 flag = 1'b1;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_busy", 64'(busy), 64'(0));
      check("drain_inst", 64'(instruction), 64'(IDLE_INST));
   endtask

   // Monitor: every bus change closes the previous op (hold check) and opens the next.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            mon_prev  = instruction;
            mon_start = cyc;
            mon_hold  = 0;
         end else if (instruction !== mon_prev) begin
            if (mon_hold > 0) check("hold_cycles", 64'(cyc - mon_start), 64'(mon_hold));
            if (instruction !== 32'(IDLE_INST)) begin
               check("issue_expected", 64'(exp_q.size() != 0), 64'(1));
               if (exp_q.size() != 0) begin
                  mon_e = exp_q.pop_front();
                  check("issue_word", 64'(instruction), 64'(mon_e.word));
                  mon_hold = int'(mon_e.hold);
               end else begin
                  mon_hold = 0;
               end
            end else begin
               check("idle_gap", 64'(exp_q.size()), 64'(0));
               mon_hold = 0;
            end
            mon_prev  = instruction;
            mon_start = cyc;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      #12;
      check("rst_inst", 64'(instruction), 64'(IDLE_INST));
      check("rst_s_ready", 64'(s_ready), 64'(1));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_level", 64'(fifo_level), 64'(0));
      check("rst_issued", 64'(issued_cnt), 64'(0));
      check("rst_timeout_err", 64'(timeout_err), 64'(0));
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // T2: three MAT_MUL, 8 cycles each, back to back
      push(mk(MAT_MUL_INST, 14'd1, 14'd2), 8, 1'b1, -1);
      push(mk(MAT_MUL_INST, 14'd3, 14'd4), 8, 1'b1, -1);
      push(mk(MAT_MUL_INST, 14'd5, 14'd6), 8, 1'b1, -1);
      wait_idle();
      exp_issued += 3;
      check("t2_issued", 64'(issued_cnt), 64'(exp_issued));

      // T3: AXI op held through the flag handshake, next op issues right after the rise
      push(mk(AXI_TO_UB_INST, 14'd5, 14'd20), 44, 1'b1, -1);
      push(mk(MAT_MUL_ACC_INST, 14'd7, 14'd9), 8, 1'b1, -1);
      axi_handshake(mk(AXI_TO_UB_INST, 14'd5, 14'd20), 3, 40);
      wait_idle();
      exp_issued += 2;
      check("t3_issued", 64'(issued_cnt), 64'(exp_issued));

      // T4: stall on an AXI op, fill the FIFO, 17th push dropped, drain in order
      push(mk(UB_TO_AXI_INST, 14'd50, 14'd51), 0, 1'b1, -1);
      wait_word(mk(UB_TO_AXI_INST, 14'd50, 14'd51));
      for (int i = 0; i < 17; i++)
         push(mk(UB_TO_DATA_FIFO_INST, 14'(100 + i), 14'(i)), 4, (i < 16), (i < 16) ? i + 1 : 16);
      check("t4_full_ready", 64'(s_ready), 64'(0));
      axi_handshake(mk(UB_TO_AXI_INST, 14'd50, 14'd51), 1, 1);
      wait_idle();
      exp_issued += 17;
      check("t4_issued", 64'(issued_cnt), 64'(exp_issued));

      // T5: mixed stream, busy falls right after the last op completes
      push(mk(UB_TO_DATA_FIFO_INST, 14'd1, 14'd1), 4, 1'b1, -1);
      push(mk(UB_TO_AXI_INST, 14'd2, 14'd2), 8, 1'b1, -1);
      push(mk(ACC_TO_UB_INST, 14'd3, 14'd3), 4, 1'b1, -1);
      axi_handshake(mk(UB_TO_AXI_INST, 14'd2, 14'd2), 2, 5);
      wait_word(mk(ACC_TO_UB_INST, 14'd3, 14'd3));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t5_busy_hi", 64'(busy), 64'(1));
      end
      @(negedge clk);
      check("t5_busy_lo", 64'(busy), 64'(0));
      exp_issued += 3;
      check("t5_issued", 64'(issued_cnt), 64'(exp_issued));

      // Unknown opcode (CYC=1) and AXI_TO_WB between counted ops
      push(mk(4'hF, 14'd10, 14'd11), 1, 1'b1, -1);
      push(mk(AXI_TO_WB_INST, 14'd12, 14'd13), 3, 1'b1, -1);
      push(mk(MAT_MUL_INST, 14'd14, 14'd15), 8, 1'b1, -1);
      axi_handshake(mk(AXI_TO_WB_INST, 14'd12, 14'd13), 1, 1);
      wait_idle();
      exp_issued += 3;
      check("t7_issued", 64'(issued_cnt), 64'(exp_issued));

      // T1: reset asserted mid S_COUNT with words still queued
      push(mk(MAT_MUL_INST, 14'd20, 14'd21), 0, 1'b1, -1);
      push(mk(MAT_MUL_INST, 14'd22, 14'd23), 0, 1'b1, -1);
      push(mk(MAT_MUL_INST, 14'd24, 14'd25), 0, 1'b1, -1);
      wait_word(mk(MAT_MUL_INST, 14'd20, 14'd21));
      repeat (3) @(posedge clk);
      check("t1_pre_level", 64'(fifo_level), 64'(2));
      check("t1_pre_issued", 64'(issued_cnt), 64'(exp_issued));
      #2 reset_n = 1'b0;
      exp_q.delete();
      exp_issued = 0;
      #1;
      check("t1_inst", 64'(instruction), 64'(IDLE_INST));
      check("t1_level", 64'(fifo_level), 64'(0));
      check("t1_issued", 64'(issued_cnt), 64'(0));
      check("t1_busy", 64'(busy), 64'(0));
      check("t1_s_ready", 64'(s_ready), 64'(1));
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      push(mk(MAT_MUL_ACC_INST, 14'd30, 14'd31), 8, 1'b1, -1);
      wait_idle();
      exp_issued += 1;
      check("post_rst_issued", 64'(issued_cnt), 64'(exp_issued));

      check("queue_empty", 64'(exp_q.size()), 64'(0));
      check("timeout_err_low", 64'(timeout_err), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
